serial_magnitude_comparator: RTL and testbench

- Parametrised, clocked successor to the cascaded one-bit comparator cell.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, carrying greater/equal state between cycles exactly as the cell chain carries it between bit positions.
- Supports signed (two's complement) and unsigned modes, optional early termination, and a start/done handshake.
- Used where a full-width combinational comparator is too large or too slow.

---
 rtl/serial_magnitude_comparator.sv | 105 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: walks two operands MSB-first, DIGIT bits per cycle,
// carrying the greater/equal cascade state between beats.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DIGIT      = 1,
    parameter int unsigned EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             greater_than,
    output logic             equal,
    output logic             less_than
);

    localparam int unsigned BEATS = WIDTH / DIGIT;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [CW-1:0]    cnt_q;
    logic             gt_q, eq_q;
    logic             gt_nxt, eq_nxt;
    logic             last_beat;

    // Ripple the one-bit cascade across the current top digit.
    always_comb begin
        gt_nxt = gt_q;
        eq_nxt = eq_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (eq_nxt) begin
                if (x_q[WIDTH-1-i] && !y_q[WIDTH-1-i]) begin
                    gt_nxt = 1'b1;
                    eq_nxt = 1'b0;
                end else if (!x_q[WIDTH-1-i] && y_q[WIDTH-1-i]) begin
                    gt_nxt = 1'b0;
                    eq_nxt = 1'b0;
                end
            end
        end
        last_beat = (cnt_q == '0) || ((EARLY_EXIT != 0) && !eq_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            gt_q         <= 1'b0;
            eq_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            greater_than <= 1'b0;
            equal        <= 1'b0;
            less_than    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Flipping both sign bits maps two's complement order onto unsigned order.
                        x_q          <= x ^ {signed_mode, {(WIDTH-1){1'b0}}};
                        y_q          <= y ^ {signed_mode, {(WIDTH-1){1'b0}}};
                        cnt_q        <= CW'(BEATS - 1);
                        gt_q         <= 1'b0;
                        eq_q         <= 1'b1;
                        greater_than <= 1'b0;
                        equal        <= 1'b0;
                        less_than    <= 1'b0;
                        busy         <= 1'b1;
                        state_q      <= StCompare;
                    end
                end
                StCompare: begin
                    gt_q  <= gt_nxt;
                    eq_q  <= eq_nxt;
                    x_q   <= x_q << DIGIT;
                    y_q   <= y_q << DIGIT;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_beat) begin
                        greater_than <= gt_nxt;
                        equal        <= eq_nxt;
                        less_than    <= ~gt_nxt & ~eq_nxt;
                        done         <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and swept checks of the serial comparator across several DIGIT/EARLY_EXIT builds.
module tb_serial_magnitude_comparator;

    localparam int NI = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sm;
    logic [15:0]   x, y;
    logic [NI-1:0] en;
    logic [NI-1:0] busy_v, done_v, gt_v, eq_v, lt_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 4) ? 8 : 4;
        localparam int unsigned E = (g == 1 || g == 3 || g == 4) ? 1 : 0;
        serial_magnitude_comparator #(
            .WIDTH(16),
            .DIGIT(D),
            .EARLY_EXIT(E)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start & en[g]),
            .signed_mode(sm),
            .x(x),
            .y(y),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .greater_than(gt_v[g]),
            .equal(eq_v[g]),
            .less_than(lt_v[g])
        );
    end

    function automatic int dig_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : (i == 4) ? 8 : 4;
    endfunction

    function automatic int ee_of(input int i);
        return (i == 1 || i == 3 || i == 4) ? 1 : 0;
    endfunction

    // Expected {gt, eq, lt}
    function automatic logic [2:0] res_exp(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
        if (s) return ($signed(a) > $signed(b)) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
        return (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
    endfunction

    function automatic int lat_exp(input logic [15:0] a, input logic [15:0] b, input int i);
        int d     = dig_of(i);
        int beats = 16 / d;
        logic [15:0] m = 16'((32'd1 << d) - 1);
        if (ee_of(i) == 0) return beats;
        for (int k = 1; k <= beats; k++)
            if (((a >> (16 - k * d)) & m) != ((b >> (16 - k * d)) & m)) return k;
        return beats;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on all masked instances; optional stray start pulses at edges 3 and 5.
    task automatic run(input logic [15:0] xv, input logic [15:0] yv, input logic smv,
                       input logic [2:0] exp, input logic [NI-1:0] mask, input bit noise);
        int         lat[NI];
        int         pulses[NI];
        int         busyc[NI];
        logic [2:0] res[NI];
        for (int i = 0; i < NI; i++) begin
            lat[i] = 0; pulses[i] = 0; busyc[i] = 0; res[i] = 3'b000;
        end
        @(negedge clk);
        x = xv; y = yv; sm = smv; en = mask; start = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (n == 0) begin
                start = 1'b0;
                check("clear_on_start", 32'({gt_v & mask, eq_v & mask, lt_v & mask}), 32'd0);
            end
            for (int i = 0; i < NI; i++) begin
                if (mask[i]) begin
                    if (busy_v[i]) busyc[i]++;
                    if (done_v[i]) begin
                        pulses[i]++;
                        if (lat[i] == 0) begin
                            lat[i] = n;
                            res[i] = {gt_v[i], eq_v[i], lt_v[i]};
                        end
                    end
                end
            end
            if (noise) begin
                if (n == 2 || n == 4) begin
                    start = 1'b1;
                    x     = 16'hFFFF;
                end else if (n == 3 || n == 5) begin
                    start = 1'b0;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                check($sformatf("latency[%0d] %h/%h", i, xv, yv), lat[i], lat_exp(xv, yv, i));
                check($sformatf("pulses[%0d]", i), pulses[i], 1);
                check($sformatf("result[%0d] %h/%h s%0d", i, xv, yv, smv), 32'(res[i]),
                      32'(exp));
                check($sformatf("busy_cycles[%0d]", i), busyc[i], lat_exp(xv, yv, i) + 1);
                check($sformatf("hold[%0d]", i), 32'({gt_v[i], eq_v[i], lt_v[i]}), 32'(exp));
            end
        end
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        while (!done_v[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int         n;
        int         pulses;
        logic [15:0] a, b;
        logic        s;
        int unsigned r;

        rst_n = 1'b0; start = 1'b0; sm = 1'b0; x = '0; y = '0; en = '1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({busy_v, done_v, gt_v, eq_v, lt_v}), 32'd0);
        rst_n = 1'b1;

        run(16'h1234, 16'h1234, 1'b0, 3'b010, '1, 1'b0);
        run(16'h8000, 16'h0001, 1'b0, 3'b100, '1, 1'b0);
        run(16'h8000, 16'h0001, 1'b1, 3'b001, '1, 1'b0);
        run(16'hFFFF, 16'hFFFE, 1'b1, 3'b100, '1, 1'b0);
        run(16'h00F1, 16'h00F0, 1'b0, 3'b100, '1, 1'b0);
        run(16'h1000, 16'h0FFF, 1'b0, 3'b100, '1, 1'b0);
        run(16'h0005, 16'h0009, 1'b0, 3'b001, 5'b01111, 1'b1);

        // Reset mid-compare; early-exit builds are already holding a result by then.
        @(negedge clk);
        x = 16'h8000; y = 16'h0000; sm = 1'b0; en = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("held_before_reset", 32'(gt_v[3]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid", 32'({busy_v, done_v, gt_v, eq_v, lt_v}), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (|done_v) pulses++;
        end
        check("no_done_after_reset", pulses, 0);
        run(16'h7FFF, 16'h8000, 1'b1, 3'b100, '1, 1'b0);

        // Back-to-back: start in the first IDLE cycle after DONE.
        @(negedge clk);
        x = 16'h0003; y = 16'h0002; sm = 1'b0; en = 5'b00001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done0(n);
        check("b2b_lat1", n, 16);
        check("b2b_res1", 32'({gt_v[0], eq_v[0], lt_v[0]}), 32'(3'b100));
        @(negedge clk);
        check("b2b_idle", 32'(busy_v[0]), 32'd0);
        x = 16'h0001; y = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept", 32'(busy_v[0]), 32'd1);
        wait_done0(n);
        check("b2b_lat2", n, 16);
        check("b2b_res2", 32'({gt_v[0], eq_v[0], lt_v[0]}), 32'(3'b001));
        repeat (2) @(negedge clk);

        for (int t = 0; t < 1000; t++) begin
            r = $urandom;
            a = 16'($urandom);
            s = r[4];
            unique case (r[1:0])
                2'd0:    b = a;
                2'd1:    b = a ^ (16'd1 << r[11:8]);
                default: b = 16'($urandom);
            endcase
            run(a, b, s, res_exp(a, b, s), '1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
